// File: rtl/barrel_shift_seq_pkg.sv
// rtl/barrel_shift_seq_pkg.sv - shared constants and state encoding for the multi-pass barrel shifter
package barrel_shift_seq_pkg;

  localparam int WIDTH = 8;
  localparam int SHW   = 3;
  localparam logic [1:0] STEP_MAX = 2'd3;

  localparam logic [1:0] MODE_SLL = 2'b00;
  localparam logic [1:0] MODE_SRL = 2'b01;
  localparam logic [1:0] MODE_SRA = 2'b10;
  localparam logic [1:0] MODE_ROL = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/barrel_shift_seq_if.sv
// rtl/barrel_shift_seq_if.sv - command/result handshake bundle of the multi-pass barrel shifter
interface barrel_shift_seq_if;
  import barrel_shift_seq_pkg::*;

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [SHW-1:0]   in_shamt;
  logic [1:0]       in_mode;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             busy;

  modport slave (
    input  in_valid, in_data, in_shamt, in_mode, out_ready,
    output in_ready, out_valid, out_data, busy
  );

  modport master (
    output in_valid, in_data, in_shamt, in_mode, out_ready,
    input  in_ready, out_valid, out_data, busy
  );

endinterface

// File: rtl/barrel_step4.sv
// rtl/barrel_step4.sv - one 4:1 mux row shifting the accumulator by 0..3 positions
module barrel_step4
  import barrel_shift_seq_pkg::*;
(
  input  logic [WIDTH-1:0] acc_i,
  input  logic [1:0]       step_i,
  input  logic [1:0]       mode_i,
  output logic [WIDTH-1:0] acc_o
);

  logic [2*WIDTH-1:0] dbl;

  always_comb begin
    acc_o = acc_i;
    dbl   = {acc_i, acc_i} << step_i;
    case (mode_i)
      MODE_SLL: acc_o = acc_i << step_i;
      MODE_SRL: acc_o = acc_i >> step_i;
      // Sign bit of the current accumulator refills the MSBs, so repeated passes compose
      MODE_SRA: acc_o = WIDTH'($signed(acc_i) >>> step_i);
      MODE_ROL: acc_o = dbl[2*WIDTH-1:WIDTH];
      default:  acc_o = acc_i;
    endcase
  end

endmodule

// File: rtl/barrel_shift_seq.sv
// rtl/barrel_shift_seq.sv - sequencer reusing one mux row over up to three passes for shifts 0..7
module barrel_shift_seq
  import barrel_shift_seq_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  barrel_shift_seq_if.slave  bus
);

  state_e           state_q;
  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] acc_d;
  logic [SHW-1:0]   rem_q;
  logic [SHW-1:0]   rem_d;
  logic [1:0]       mode_q;
  logic [1:0]       step;

  assign step  = (rem_q > SHW'(STEP_MAX)) ? STEP_MAX : rem_q[1:0];
  assign rem_d = rem_q - SHW'(step);

  barrel_step4 u_row (
    .acc_i  (acc_q),
    .step_i (step),
    .mode_i (mode_q),
    .acc_o  (acc_d)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      acc_q   <= '0;
      rem_q   <= '0;
      mode_q  <= MODE_SLL;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.in_valid) begin
            acc_q   <= bus.in_data;
            rem_q   <= bus.in_shamt;
            mode_q  <= bus.in_mode;
            state_q <= (bus.in_shamt == '0) ? ST_DONE : ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          acc_q <= acc_d;
          rem_q <= rem_d;
          if (rem_d == '0) state_q <= ST_DONE;
        end
        ST_DONE: begin
          if (bus.out_ready) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (state_q == ST_IDLE);
  assign bus.out_valid = (state_q == ST_DONE);
  assign bus.busy      = (state_q == ST_SHIFT) || (state_q == ST_DONE);
  assign bus.out_data  = acc_q;

endmodule

// File: tb/tb_barrel_shift_seq.sv
// tb/tb_barrel_shift_seq.sv - self-checking bench for barrel_shift_seq
module tb_barrel_shift_seq;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;

  barrel_shift_seq_if bus ();

  barrel_shift_seq dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] ref_shift(input logic [7:0] d, input int s, input logic [1:0] m);
    logic [7:0] r;
    r = d;
    for (int k = 0; k < s; k++) begin
      case (m)
        2'b00:   r = {r[6:0], 1'b0};
        2'b01:   r = {1'b0, r[7:1]};
        2'b10:   r = {r[7], r[7:1]};
        default: r = {r[6:0], r[7]};
      endcase
    end
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic run_cmd(input logic [7:0] d, input logic [2:0] s, input logic [1:0] m, input int hold);
    int         edges;
    logic [7:0] exp;
    exp = ref_shift(d, int'(s), m);
    check("in_ready_idle", 32'(bus.in_ready), 32'd1);
    bus.in_valid  = 1'b1;
    bus.in_data   = d;
    bus.in_shamt  = s;
    bus.in_mode   = m;
    bus.out_ready = (hold == 0);
    edges = 0;
    do begin
      @(posedge clk);
      edges++;
      @(negedge clk);
      bus.in_valid = 1'($urandom);
      bus.in_data  = 8'($urandom);
      bus.in_shamt = 3'($urandom);
      bus.in_mode  = 2'($urandom);
    end while (!bus.out_valid && edges < 10);
    bus.in_valid = 1'b0;
    check("latency", 32'(edges), 32'(1 + (int'(s) + 2) / 3));
    check("out_data", 32'(bus.out_data), 32'(exp));
    check("busy_done", 32'(bus.busy), 32'd1);
    check("in_ready_done", 32'(bus.in_ready), 32'd0);
    for (int k = 0; k < hold; k++) begin
      @(posedge clk);
      @(negedge clk);
      check("hold_valid", 32'(bus.out_valid), 32'd1);
      check("hold_data", 32'(bus.out_data), 32'(exp));
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("idle_valid", 32'(bus.out_valid), 32'd0);
    check("idle_busy", 32'(bus.busy), 32'd0);
    bus.out_ready = 1'b0;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_shamt  = '0;
    bus.in_mode   = '0;
    bus.out_ready = 1'b0;

    // Async reset, before any clock edge
    #1;
    check("rst_valid", 32'(bus.out_valid), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_ready", 32'(bus.in_ready), 32'd1);
    check("rst_data", 32'(bus.out_data), 32'h00);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("post_rst_ready", 32'(bus.in_ready), 32'd1);
    check("post_rst_busy", 32'(bus.busy), 32'd0);

    // Directed cases
    run_cmd(8'hB3, 3'd5, 2'b00, 0);
    run_cmd(8'h90, 3'd7, 2'b10, 1);
    run_cmd(8'h90, 3'd7, 2'b01, 0);
    run_cmd(8'hB3, 3'd4, 2'b11, 0);
    run_cmd(8'h81, 3'd1, 2'b11, 2);
    check("sll_b3_5", 32'(ref_shift(8'hB3, 5, 2'b00)), 32'h60);

    // Held result blocks a second command
    bus.in_valid = 1'b1; bus.in_data = 8'h80; bus.in_shamt = 3'd0; bus.in_mode = 2'b01;
    @(posedge clk);
    @(negedge clk);
    bus.in_data = 8'h55; bus.in_shamt = 3'd1; bus.in_mode = 2'b00;
    check("zero_valid", 32'(bus.out_valid), 32'd1);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      @(negedge clk);
      check("stall_data", 32'(bus.out_data), 32'h80);
      check("stall_ready", 32'(bus.in_ready), 32'd0);
      check("stall_valid", 32'(bus.out_valid), 32'd1);
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("release_idle", 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    check("second_busy", 32'(bus.busy), 32'd1);
    @(posedge clk);
    @(negedge clk);
    check("second_valid", 32'(bus.out_valid), 32'd1);
    check("second_data", 32'(bus.out_data), 32'hAA);
    @(posedge clk);
    @(negedge clk);
    bus.out_ready = 1'b0;
    check("second_idle", 32'(bus.in_ready), 32'd1);

    // Abort mid-shift with async reset
    bus.in_valid = 1'b1; bus.in_data = 8'h90; bus.in_shamt = 3'd7; bus.in_mode = 2'b10;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("abort_pre_busy", 32'(bus.busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("abort_valid", 32'(bus.out_valid), 32'd0);
    check("abort_busy", 32'(bus.busy), 32'd0);
    check("abort_ready", 32'(bus.in_ready), 32'd1);
    check("abort_data", 32'(bus.out_data), 32'h00);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_cmd(8'h01, 3'd3, 2'b00, 0);

    // Randomized commands against the reference model
    for (int n = 0; n < 24; n++) begin
      run_cmd(8'($urandom), 3'($urandom), 2'($urandom), int'($urandom_range(0, 2)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/barrel_shift_seq.md
Name: barrel_shift_seq

Overview:
- Multi-pass sequencer for the 8-bit barrel shifter built from 4:1 mux rows.
- One mux row shifts by 0..3 positions. This block holds an accumulator and reuses that single row over up to 3 clock cycles to realise any shift amount 0..7.
- It sits between a valid/ready command source and a valid/ready result consumer.
- Supported modes: logical left, logical right, arithmetic right, rotate left.

Parameters:
- WIDTH, 8, data width in bits.
- SHW, 3, shift-amount width (log2 WIDTH).
- STEP_MAX, 3, largest shift one mux row applies per pass (4:1 mux, selects 0..3).

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- in_valid  input  1  command present.
- in_ready  output  1  block can accept a command; high only in IDLE.
- in_data  input  WIDTH  operand.
- in_shamt  input  SHW  shift amount 0..7.
- in_mode  input  2  00 SLL, 01 SRL, 10 SRA, 11 ROL.
- out_valid  output  1  result valid; high only in DONE.
- out_ready  input  1  consumer accepts result.
- out_data  output  WIDTH  shifted result; driven from the accumulator register.
- busy  output  1  high in SHIFT or DONE.

Behaviour:
- Reset (async, rst_n low, no clock required):
  - state=IDLE; acc=0; rem=0; mode_q=00.
  - out_valid=0, out_data=0, busy=0, in_ready=1.
- States: IDLE, SHIFT, DONE. in_ready, out_valid and busy decode combinationally from state.
- IDLE:
  - Accept when in_valid & in_ready: acc<=in_data, rem<=in_shamt, mode_q<=in_mode.
  - Next state is DONE if in_shamt==0, else SHIFT.
- SHIFT, one pass per cycle:
  - step=min(rem,STEP_MAX); acc<=row(acc,step,mode_q); rem<=rem-step.
  - Go to DONE when rem-step==0, else stay in SHIFT.
  - Pass sequence for shamt 7 is 3,3,1.
- Row fill rules:
  - SLL: zeros enter at LSB.
  - SRL: zeros enter at MSB.
  - SRA: copies of acc[WIDTH-1] enter at MSB. The sign is preserved across passes, so the multi-pass result equals a single arithmetic shift.
  - ROL: bits leaving MSB re-enter at LSB.
- DONE:
  - out_valid=1; out_data=acc, held stable while out_ready=0.
  - On out_ready, go to IDLE next edge. No same-cycle re-accept.
- Latency: out_valid rises 1+ceil(shamt/3) rising edges after the accepting edge.
  - shamt 0 → 1; 1..3 → 2; 4..6 → 3; 7 → 4.
- Throughput: one command per latency+1 cycles minimum (the extra cycle is the IDLE return).
- in_valid outside IDLE is ignored. Command inputs are sampled only on the accepting edge, so later changes have no effect.
- Async reset mid-SHIFT or mid-DONE aborts the operation. Outputs take their reset values immediately and no stale result appears after release.
- Width rules: rem is SHW bits and never underflows, since step<=rem. in_shamt>=WIDTH is impossible at SHW=log2 WIDTH.

Decomposition:
- Shared package/header holds:
  - mode constants MODE_SLL=2'b00, MODE_SRL=2'b01, MODE_SRA=2'b10, MODE_ROL=2'b11.
  - state encoding ST_IDLE, ST_SHIFT, ST_DONE.
  - STEP_MAX.
- Sub-module barrel_step4: combinational row of WIDTH 4:1 muxes.
  - Inputs: acc, step[1:0], mode.
  - Output: next acc.
  - Fill/wrap bits are selected per mode.
- barrel_shift_seq contains only the FSM, acc/rem/mode_q registers and handshake decode.

Test Plan:
- Reset: hold rst_n=0 with no clock edges → immediately out_valid=0, busy=0, in_ready=1, out_data=8'h00. After release, state stays IDLE with in_valid=0.
- SLL in_data=8'hB3, shamt=5 → passes 3,2 → out_data=8'h60, out_valid exactly 3 edges after accept. busy=1 from accept until the result handshake.
- SRA in_data=8'h90, shamt=7 → passes 3,3,1 → out_data=8'hFF after 4 edges. SRL with the same inputs → 8'h01.
- ROL in_data=8'hB3, shamt=4 → 8'h3B after 3 edges. ROL 8'h81, shamt=1 → 8'h03 after 2 edges.
- SRL 8'h80, shamt=0 → 8'h80 one edge after accept.
  - Hold out_ready=0 for 5 cycles: out_data stays 8'h80, in_ready=0, and a second in_valid with 8'h55 is not accepted.
  - Release out_ready: IDLE next edge, then the 8'h55 command is accepted.
- Async reset during the second pass of SRA 8'h90 shamt 7 → out_valid/busy drop without a clock edge, in_ready=1.
  - After release, a new SLL 8'h01 shamt 3 returns 8'h08 with no residue of the aborted command.
